// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared defaults and the RAM bus operation encoding for the RAM-backed FIFO controller.
package ram_fifo_ctrl_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_WR   = 2'd1,
    OP_RD   = 2'd2
  } ram_op_e;

endpackage

// File: rtl/ram_fifo_out_stage.sv
// One-entry output register fed by the RAM read port.
// Tracks the in-flight read and owns the pop handshake.
module ram_fifo_out_stage #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              rd_launch,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              pop_ready,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data,
  output logic              rd_infl,
  output logic              out_valid
);

  logic              rd_infl_q, rd_infl_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_reg_q, out_reg_d;

  always_comb begin
    rd_infl_d   = rd_launch;
    out_valid_d = out_valid_q;
    out_reg_d   = out_reg_q;
    if (clr) begin
      // Clearing rd_infl here is what discards a read that is still in flight.
      rd_infl_d   = 1'b0;
      out_valid_d = 1'b0;
    end else if (rd_infl_q) begin
      out_valid_d = 1'b1;
      out_reg_d   = ram_rdata;
    end else if (pop_valid && pop_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rd_infl_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_reg_q   <= '0;
    end else begin
      rd_infl_q   <= rd_infl_d;
      out_valid_q <= out_valid_d;
      out_reg_q   <= out_reg_d;
    end
  end

  assign pop_valid = out_valid_q & ~clr;
  assign pop_data  = out_reg_q;
  assign rd_infl   = rd_infl_q;
  assign out_valid = out_valid_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port RAM: pointers, occupancy and bus arbitration.
// Reads have priority; the oldest word is prefetched into the output stage.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic              ram_cs,
  output logic              ram_write,
  output logic              ram_read,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
  logic              clr, rd_issue, wr_fire, cnt_full, rd_infl, out_valid;
  ram_op_e           bus_op;

  assign clr      = rst | flush;
  assign cnt_full = (ram_cnt_q == (ADDR_W+1)'(DEPTH));
  // A read only issues when nothing is in flight or buffered, so it never starves writes.
  assign rd_issue = (ram_cnt_q != '0) & ~rd_infl & ~out_valid & ~clr;
  assign push_ready = ~cnt_full & ~rd_issue & ~clr;
  assign wr_fire  = push_valid & push_ready;

  always_comb begin
    bus_op = OP_IDLE;
    if (rd_issue)     bus_op = OP_RD;
    else if (wr_fire) bus_op = OP_WR;
  end

  always_comb begin
    ram_write = 1'b0;
    ram_read  = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (bus_op)
      OP_WR: begin
        ram_write = 1'b1;
        ram_addr  = wr_ptr_q;
        ram_wdata = push_data;
      end
      OP_RD: begin
        ram_read = 1'b1;
        ram_addr = rd_ptr_q;
      end
      default: ;
    endcase
  end

  assign ram_cs = ram_write | ram_read;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q;
    if (wr_fire) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      ram_cnt_d = ram_cnt_q + 1'b1;
    end
    if (rd_issue) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      ram_cnt_d = ram_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
    end
  end

  ram_fifo_out_stage #(.DATA_W(DATA_W)) u_out (
    .clk       (clk),
    .clr       (clr),
    .rd_launch (rd_issue),
    .ram_rdata (ram_rdata),
    .pop_ready (pop_ready),
    .pop_valid (pop_valid),
    .pop_data  (pop_data),
    .rd_infl   (rd_infl),
    .out_valid (out_valid)
  );

  always_comb begin
    level = '0;
    if (!clr)
      level = ram_cnt_q + {{ADDR_W{1'b0}}, rd_infl} + {{ADDR_W{1'b0}}, out_valid};
  end

  assign full  = cnt_full & ~clr;
  assign empty = (level == '0);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl with a behavioural 256x4 RAM on the ram_* bus.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst, flush;
  logic       push_valid, push_ready;
  logic [3:0] push_data;
  logic       pop_valid, pop_ready;
  logic [3:0] pop_data;
  logic       ram_cs, ram_write, ram_read;
  logic [7:0] ram_addr;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata;
  logic [8:0] level;
  logic       full, empty;

  int total = 0;
  int bad   = 0;
  int model_level = 0;
  logic [3:0] sb[$];
  bit prod_done;

  always #5 clk = ~clk;

  ram_fifo_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_data   (pop_data),
    .ram_cs     (ram_cs),
    .ram_write  (ram_write),
    .ram_read   (ram_read),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .level      (level),
    .full       (full),
    .empty      (empty)
  );

  // Behavioural single-port RAM: registered read, data the cycle after read is sampled.
  logic [3:0] mem [256];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_write) mem[ram_addr] <= ram_wdata;
      if (ram_read)  ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the model tracks accepted-but-not-popped words.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
      model_level = 0;
    end else begin
      chk("level", int'(level), model_level);
      chk("empty", int'(empty), int'(model_level == 0));
      chk("bus_excl", int'(ram_read & ram_write), 0);
      chk("ram_cs", int'(ram_cs), int'(ram_read | ram_write));
      if (pop_valid && pop_ready) begin
        if (sb.size() == 0) begin
          chk("pop_unexpected", 1, 0);
        end else begin
          logic [3:0] e;
          e = sb.pop_front();
          chk("pop_data", int'(pop_data), int'(e));
          model_level--;
        end
      end
      if (push_valid && push_ready) begin
        sb.push_back(push_data);
        model_level++;
      end
    end
  end

  task automatic do_push(input logic [3:0] d);
    int n = 0;
    push_valid = 1'b1;
    push_data  = d;
    @(negedge clk);
    while (!push_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!push_ready) chk("push_timeout", 1, 0);
    @(posedge clk); #1;
    push_valid = 1'b0;
  endtask

  task automatic wait_empty(input int bound);
    int n = 0;
    @(negedge clk);
    while (!empty && n < bound) begin
      n++;
      @(negedge clk);
    end
    chk("drain_empty", int'(empty), 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      chk("rst_push_ready", int'(push_ready), 0);
      chk("rst_pop_valid", int'(pop_valid), 0);
      chk("rst_ram_cs", int'(ram_cs), 0);
      chk("rst_ram_rw", int'({ram_write, ram_read}), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_push_ready", int'(push_ready), 1);
    chk("post_rst_pop_valid", int'(pop_valid), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
    do_reset(2);

    // Latency: first word pops in cycle 3 after its push.
    pop_ready = 1'b1;
    do_push(4'h1);
    do_push(4'h2);
    @(negedge clk);
    chk("lat_pop_valid", int'(pop_valid), 1);
    chk("lat_pop_data", int'(pop_data), 1);
    @(posedge clk); #1;
    wait_empty(50);

    // Read wins the bus when it collides with a push; the write lands next cycle.
    do_reset(1);
    pop_ready = 1'b0;
    do_push(4'h5);
    push_valid = 1'b1;
    push_data  = 4'h6;
    @(negedge clk);
    chk("coll_ram_read", int'(ram_read), 1);
    chk("coll_ram_write", int'(ram_write), 0);
    chk("coll_push_ready", int'(push_ready), 0);
    chk("coll_rd_addr", int'(ram_addr), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("coll_wr_next", int'(ram_write), 1);
    chk("coll_wr_addr", int'(ram_addr), 1);
    @(posedge clk); #1;
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    wait_empty(50);

    // Fill: 256 in RAM plus one in the output register.
    do_reset(1);
    pop_ready = 1'b0;
    for (int i = 0; i < 257; i++) do_push(i[3:0]);
    @(negedge clk);
    chk("fill_full", int'(full), 1);
    chk("fill_push_ready", int'(push_ready), 0);
    chk("fill_level", int'(level), 257);
    @(posedge clk); #1;
    push_valid = 1'b1;
    push_data  = 4'hA;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("full_held", int'(push_ready), 0);
      @(posedge clk); #1;
    end
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    wait_empty(2000);

    // Reset mid-traffic; stale RAM read data must never pop.
    pop_ready = 1'b0;
    do_push(4'h7);
    do_push(4'h8);
    do_push(4'h9);
    pop_ready = 1'b1;
    do_reset(2);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("stale_pop_valid", int'(pop_valid), 0);
      @(posedge clk); #1;
    end

    // Flush with three words in RAM and one read in flight.
    pop_ready = 1'b0;
    for (int i = 1; i <= 5; i++) do_push(i[3:0]);
    pop_ready = 1'b1;
    @(negedge clk);
    chk("fl_pop_valid", int'(pop_valid), 1);
    @(posedge clk); #1;
    pop_ready = 1'b0;
    @(negedge clk);
    chk("fl_rd_issue", int'(ram_read), 1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("fl_pop_valid0", int'(pop_valid), 0);
    chk("fl_level0", int'(level), 0);
    chk("fl_empty", int'(empty), 1);
    chk("fl_push_ready", int'(push_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("fl_after_pop_valid", int'(pop_valid), 0);
      @(posedge clk); #1;
    end
    pop_ready = 1'b1;
    do_push(4'hC);
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("fl_repush_valid", int'(pop_valid), 1);
    chk("fl_repush_data", int'(pop_data), 12);
    @(posedge clk); #1;
    wait_empty(50);

    // Wrap: 600 words with random producer gaps and consumer stalls.
    do_reset(1);
    prod_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 600; i++) begin
          int gap;
          gap = $urandom_range(0, 2);
          for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
          end
          do_push(i[3:0]);
        end
        prod_done = 1'b1;
      end
      begin
        while (!prod_done) begin
          pop_ready = ($urandom_range(0, 1) == 1);
          @(posedge clk); #1;
        end
      end
    join
    pop_ready = 1'b1;
    wait_empty(3000);
    chk("wrap_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
